// File: rtl/da_pkg.sv
// -----------------------------------------------------------------------------
// da_pkg
//   Shared definitions for the three-input distributed-arithmetic MAC.
//   ROM_ADDR_W : one address bit per input sample (x0 -> bit 0 ... x2 -> bit 2)
//   ROM_DATA_W : ROM word width. It holds any sum of three 4-bit signed weights.
//   COEFF_W    : width of each signed coefficient
//   state_t    : MAC sequencer state, 2-bit encoding
// -----------------------------------------------------------------------------
package da_pkg;

  localparam int ROM_ADDR_W = 3;
  localparam int ROM_DATA_W = 6;
  localparam int COEFF_W    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Converts an integer weight to a sign-extended ROM-width value.
  // Weights lie in [-8, 7], so the conversion is exact.
  function automatic logic signed [ROM_DATA_W-1:0] coeff_to_word(input int c);
    logic signed [COEFF_W-1:0] narrow;
    narrow = COEFF_W'(c);
    return {{(ROM_DATA_W-COEFF_W){narrow[COEFF_W-1]}}, narrow};
  endfunction

endpackage

// File: rtl/da_rom_3.sv
// -----------------------------------------------------------------------------
// da_rom_3
//   Combinational three-input DA ROM. For address bit pattern {b2,b1,b0} it
//   returns b0*COEFFICIENT_0 + b1*COEFFICIENT_1 + b2*COEFFICIENT_2.
//   Ports:
//     addr  in  ROM_ADDR_W  bit-slice {x2[k], x1[k], x0[k]}
//     data  out ROM_DATA_W  signed partial-sum word
//   Parameters:
//     COEFFICIENT_0..2  signed 4-bit weights (integer values in [-8, 7])
// -----------------------------------------------------------------------------
module da_rom_3
  import da_pkg::*;
#(
  parameter int COEFFICIENT_0 = 1,
  parameter int COEFFICIENT_1 = 1,
  parameter int COEFFICIENT_2 = 1
) (
  input  logic        [ROM_ADDR_W-1:0] addr,
  output logic signed [ROM_DATA_W-1:0] data
);

  localparam logic signed [ROM_DATA_W-1:0] W0 = coeff_to_word(COEFFICIENT_0);
  localparam logic signed [ROM_DATA_W-1:0] W1 = coeff_to_word(COEFFICIENT_1);
  localparam logic signed [ROM_DATA_W-1:0] W2 = coeff_to_word(COEFFICIENT_2);

  // The largest magnitude is 3 * 8 = 24, so the 6-bit word never wraps.
  always_comb begin
    data = '0;
    if (addr[0]) data = data + W0;
    if (addr[1]) data = data + W1;
    if (addr[2]) data = data + W2;
  end

endmodule

// File: rtl/da_mac_3.sv
// -----------------------------------------------------------------------------
// da_mac_3
//   Bit-serial distributed-arithmetic MAC computing
//     result = COEFFICIENT_0*x0 + COEFFICIENT_1*x1 + COEFFICIENT_2*x2
//   A sample set is taken in IDLE. The block then spends DATA_WIDTH cycles in
//   SHIFT, with one bit-slice per cycle, LSB first. It then holds the result in
//   DONE until that result is consumed.
//
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both high. in_ready is high only in IDLE and out_valid is high only in
//   DONE, so the two are never high together and jobs never overlap. Both
//   flags and result come directly from registers.
//
//   Ports:
//     clk        in   rising-edge clock
//     rst        in   asynchronous active-high reset
//     in_valid   in   x0..x2 valid
//     in_ready   out  block can accept a sample set (IDLE)
//     x0..x2     in   DATA_WIDTH signed samples (ROM address bits 0..2)
//     out_valid  out  result valid (DONE)
//     out_ready  in   downstream accepts result
//     result     out  OUT_WIDTH signed dot product
// -----------------------------------------------------------------------------
module da_mac_3
  import da_pkg::*;
#(
  parameter int DATA_WIDTH    = 4,
  parameter int OUT_WIDTH     = 10,
  parameter int COEFFICIENT_0 = 1,
  parameter int COEFFICIENT_1 = 1,
  parameter int COEFFICIENT_2 = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] x0,
  input  logic [DATA_WIDTH-1:0] x1,
  input  logic [DATA_WIDTH-1:0] x2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  result
);

  localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  state_t                       state;
  logic        [DATA_WIDTH-1:0] sr0, sr1, sr2;
  logic        [CNT_W-1:0]      cnt;
  logic signed [OUT_WIDTH-1:0]  acc;

  logic        [ROM_ADDR_W-1:0] rom_addr;
  logic signed [ROM_DATA_W-1:0] rom_data;
  logic signed [OUT_WIDTH-1:0]  rom_ext;
  logic signed [OUT_WIDTH-1:0]  term;
  logic signed [OUT_WIDTH-1:0]  acc_next;
  logic                         last_slice;

  // Bit-slice address: bit k of every sample, taken from the shift-register LSBs.
  assign rom_addr = {sr2[0], sr1[0], sr0[0]};

  da_rom_3 #(
    .COEFFICIENT_0 (COEFFICIENT_0),
    .COEFFICIENT_1 (COEFFICIENT_1),
    .COEFFICIENT_2 (COEFFICIENT_2)
  ) u_rom (
    .addr (rom_addr),
    .data (rom_data)
  );

  // The MSB slice has negative weight in two's complement, so it is
  // subtracted. The output width leaves headroom, so no saturation is needed.
  always_comb begin
    rom_ext    = {{(OUT_WIDTH-ROM_DATA_W){rom_data[ROM_DATA_W-1]}}, rom_data};
    term       = rom_ext <<< cnt;
    last_slice = (cnt == LAST_CNT);
    acc_next   = last_slice ? (acc - term) : (acc + term);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      sr0       <= '0;
      sr1       <= '0;
      sr2       <= '0;
      cnt       <= '0;
      acc       <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Samples are captured only on the accepting edge.
          if (in_valid) begin
            sr0      <= x0;
            sr1      <= x1;
            sr2      <= x2;
            acc      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= SHIFT;
          end
        end

        SHIFT: begin
          acc <= acc_next;
          sr0 <= sr0 >> 1;
          sr1 <= sr1 >> 1;
          sr2 <= sr2 >> 1;
          if (last_slice) begin
            cnt       <= '0;
            result    <= acc_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DONE: begin
          // result stays unchanged until downstream takes it.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_da_mac_3.sv
// -----------------------------------------------------------------------------
// tb_da_mac_3
//   Four instances with different weight sets share one stimulus stream:
//     0: defaults (1,1,1)   1: (3,-2,5)   2: (-8,-8,-8)   3: (7,7,7)
//   Directed jobs are checked against hand-computed dot products. A random
//   back-to-back run is checked against a scoreboard queue.
// -----------------------------------------------------------------------------
module tb_da_mac_3;

  localparam int DW = 4;
  localparam int OW = 10;
  localparam int NI = 4;
  localparam int N_RAND = 1000;

  localparam int CA [NI] = '{1,  3, -8, 7};
  localparam int CB [NI] = '{1, -2, -8, 7};
  localparam int CC [NI] = '{1,  5, -8, 7};

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 out_ready;
  logic signed [DW-1:0] x0, x1, x2;
  logic [NI-1:0]        in_ready_v;
  logic [NI-1:0]        out_valid_v;
  logic signed [OW-1:0] result_v [NI];

  int errors = 0;
  int checks = 0;
  logic [NI*OW-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  da_mac_3 #(.DATA_WIDTH(DW), .OUT_WIDTH(OW),
             .COEFFICIENT_0(1), .COEFFICIENT_1(1), .COEFFICIENT_2(1)) u_def (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[0]),
    .x0(x0), .x1(x1), .x2(x2), .out_valid(out_valid_v[0]),
    .out_ready(out_ready), .result(result_v[0]));

  da_mac_3 #(.DATA_WIDTH(DW), .OUT_WIDTH(OW),
             .COEFFICIENT_0(3), .COEFFICIENT_1(-2), .COEFFICIENT_2(5)) u_mix (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[1]),
    .x0(x0), .x1(x1), .x2(x2), .out_valid(out_valid_v[1]),
    .out_ready(out_ready), .result(result_v[1]));

  da_mac_3 #(.DATA_WIDTH(DW), .OUT_WIDTH(OW),
             .COEFFICIENT_0(-8), .COEFFICIENT_1(-8), .COEFFICIENT_2(-8)) u_neg (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[2]),
    .x0(x0), .x1(x1), .x2(x2), .out_valid(out_valid_v[2]),
    .out_ready(out_ready), .result(result_v[2]));

  da_mac_3 #(.DATA_WIDTH(DW), .OUT_WIDTH(OW),
             .COEFFICIENT_0(7), .COEFFICIENT_1(7), .COEFFICIENT_2(7)) u_pos (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[3]),
    .x0(x0), .x1(x1), .x2(x2), .out_valid(out_valid_v[3]),
    .out_ready(out_ready), .result(result_v[3]));

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int model(input int i, input int a, input int b, input int c);
    return CA[i] * a + CB[i] * b + CC[i] * c;
  endfunction

  task automatic check_results(input string tag, input int a, input int b, input int c);
    for (int i = 0; i < NI; i++)
      check($sformatf("%s_r%0d", tag, i), result_v[i], model(i, a, b, c));
  endtask

  // ---------------- drivers ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Called 1 ns after an edge; returns 1 ns after the accepting edge.
  task automatic start_job(input string tag, input int a, input int b, input int c);
    x0 = DW'(a);
    x1 = DW'(b);
    x2 = DW'(c);
    in_valid = 1'b1;
    check({tag, "_rdy_in"}, in_ready_v, 4'hF);
    cycle();
    in_valid = 1'b0;
  endtask

  // Waits (bounded) for the result, then checks latency, flags and values.
  task automatic wait_result(input string tag, input int a, input int b, input int c);
    int k = 0;
    while (out_valid_v == '0 && k < 20) begin
      check({tag, "_busy"}, in_ready_v, 4'h0);
      cycle();
      k++;
    end
    check({tag, "_lat"}, k, DW);
    check({tag, "_ovld"}, out_valid_v, 4'hF);
    check({tag, "_rdy_dn"}, in_ready_v, 4'h0);
    check_results(tag, a, b, c);
  endtask

  task automatic finish_job(input string tag);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    check({tag, "_ovld_clr"}, out_valid_v, 4'h0);
    check({tag, "_rdy_back"}, in_ready_v, 4'hF);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    x0 = '0; x1 = '0; x2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdy", in_ready_v, 4'hF);
    check("rst_ovld", out_valid_v, 4'h0);
    check_results("rst_res", 0, 0, 0);
    rst = 1'b0;
    cycle();

    // 1: x=(1,1,1): 3, 6, -24, 21
    start_job("t1", 1, 1, 1);
    wait_result("t1", 1, 1, 1);
    check("t1_def_res", result_v[0], 3);
    finish_job("t1");

    // 2: x=(7,-8,0): mixed weights give 37
    start_job("t2", 7, -8, 0);
    wait_result("t2", 7, -8, 0);
    check("t2_mix_res", result_v[1], 37);
    finish_job("t2");

    // 3: x=(-8,-8,-8): -8 weights give 192, 7 weights give -168
    start_job("t3", -8, -8, -8);
    wait_result("t3", -8, -8, -8);
    check("t3_neg_res", result_v[2], 192);
    check("t3_pos_res", result_v[3], -168);
    finish_job("t3");

    // 4: backpressure with ignored in_valid pulses
    start_job("t4", 5, -3, 2);
    wait_result("t4", 5, -3, 2);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      x0 = 4'sd1; x1 = 4'sd2; x2 = 4'sd3;
      cycle();
      check($sformatf("t4_hold_ovld%0d", i), out_valid_v, 4'hF);
      check($sformatf("t4_hold_rdy%0d", i), in_ready_v, 4'h0);
      check_results($sformatf("t4_hold%0d", i), 5, -3, 2);
    end
    in_valid = 1'b0;
    finish_job("t4");
    cycle();
    check("t4_idle_rdy", in_ready_v, 4'hF);

    // 5: async reset mid-SHIFT (cnt=2), then a fresh job
    start_job("t5a", 1, 1, 1);
    cycle();
    cycle();
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_rdy", in_ready_v, 4'hF);
    check("t5_rst_ovld", out_valid_v, 4'h0);
    check_results("t5_rst_res", 0, 0, 0);
    #1;
    rst = 1'b0;
    cycle();
    check("t5_no_spur", out_valid_v, 4'h0);
    start_job("t5b", 2, 0, 0);
    wait_result("t5b", 2, 0, 0);
    check("t5_mix_res", result_v[1], 6);
    finish_job("t5b");

    // 6: back-to-back random jobs, out_ready tied high
    begin
      int accepted = 0;
      int done = 0;
      int cyc = 0;
      int last_acc = -1;
      logic [NI*OW-1:0] e;
      bit take;
      out_ready = 1'b1;
      x0 = DW'($urandom_range(0, 15));
      x1 = DW'($urandom_range(0, 15));
      x2 = DW'($urandom_range(0, 15));
      while (done < N_RAND && cyc < N_RAND * 6 + 100) begin
        in_valid = (accepted < N_RAND);
        take = in_valid && (in_ready_v == 4'hF);
        check("t6_excl", in_ready_v & out_valid_v, 4'h0);
        if (take) begin
          for (int i = 0; i < NI; i++)
            e[i*OW +: OW] = OW'(model(i, int'(x0), int'(x1), int'(x2)));
          exp_q.push_back(e);
          if (last_acc >= 0) check("t6_rate", cyc - last_acc, DW + 2);
          last_acc = cyc;
          accepted++;
        end
        if (out_valid_v != '0) begin
          if (exp_q.size() == 0) begin
            check("t6_unexpected", out_valid_v, 4'h0);
          end else begin
            e = exp_q.pop_front();
            for (int i = 0; i < NI; i++)
              check($sformatf("t6_r%0d", i), result_v[i], $signed(e[i*OW +: OW]));
            done++;
          end
        end
        cycle();
        cyc++;
        if (take) begin
          x0 = DW'($urandom_range(0, 15));
          x1 = DW'($urandom_range(0, 15));
          x2 = DW'($urandom_range(0, 15));
        end
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      check("t6_done", done, N_RAND);
      check("t6_q_empty", exp_q.size(), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
